// File: rtl/demux1x4_buf_pkg.sv
// Shared constants, types and helpers for the buffered 1-to-4 demultiplexer.
// Lane occupancy is packed two bits per lane into a single status vector.
package demux1x4_buf_pkg;

    localparam int LANES     = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 2;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;

    typedef logic [CNT_W-1:0]       lane_cnt_t;
    typedef logic [LANES*CNT_W-1:0] lane_cnt_vec_t;

    typedef enum logic [SEL_W-1:0] {
        LANE_0 = 2'd0,
        LANE_1 = 2'd1,
        LANE_2 = 2'd2,
        LANE_3 = 2'd3
    } lane_e;

    // Pulls the occupancy of one lane out of the packed status vector.
    function automatic lane_cnt_t lane_cnt_of(input lane_cnt_vec_t packed_cnt,
                                              input logic [SEL_W-1:0] lane);
        return packed_cnt[lane*CNT_W +: CNT_W];
    endfunction

endpackage

// File: rtl/lane_fifo2.sv
// One output lane: up to two buffered words with wrap-around pointers and a
// separate count. The head word is held in its own register so it stays put once the lane drains.
module lane_fifo2
    import demux1x4_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [2];
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] cnt_after_pop_s;
    logic             rd_r;
    logic             wr_r;
    logic             rd_next_s;
    logic             wr_next_s;
    logic             valid_r;
    logic             full_r;
    logic             push_s;
    logic             pop_s;

    // A single-entry lane keeps both pointers pinned to slot 0.
    function automatic logic ptr_inc(input logic ptr);
        if (DEPTH == 2) begin
            return ~ptr;
        end else begin
            return 1'b0;
        end
    endfunction

    // Guard against overflow and underflow regardless of what the caller drives.
    always_comb begin
        push_s = push & ~full_r;
        pop_s  = pop & valid_r;
    end

    // Next-state for pointers, count and head word.
    always_comb begin
        cnt_after_pop_s = cnt_r - CNT_W'(pop_s);
        cnt_next_s      = cnt_after_pop_s + CNT_W'(push_s);
        if (pop_s) begin
            rd_next_s = ptr_inc(rd_r);
        end else begin
            rd_next_s = rd_r;
        end
        if (push_s) begin
            wr_next_s = ptr_inc(wr_r);
        end else begin
            wr_next_s = wr_r;
        end
        // When the lane is empty after the pop, a fresh push goes straight to the head.
        if (cnt_after_pop_s == '0) begin
            if (push_s) begin
                head_next_s = din;
            end else begin
                head_next_s = head_r;
            end
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Lane state registers; reset discards every buffered word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            head_r   <= '0;
            cnt_r    <= '0;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_r] <= din;
            end
            head_r  <= head_next_s;
            cnt_r   <= cnt_next_s;
            rd_r    <= rd_next_s;
            wr_r    <= wr_next_s;
            valid_r <= (cnt_next_s != '0);
            full_r  <= (cnt_next_s == DEPTH_C);
        end
    end

    assign dout  = head_r;
    assign valid = valid_r;
    assign full  = full_r;
    assign cnt   = cnt_r;

endmodule

// File: rtl/demux1x4_buf.sv
// Registered 1-to-4 demultiplexer: steers each accepted word to the lane named
// by in_sel, where it waits in that lane's small FIFO until its consumer takes it.
module demux1x4_buf
    import demux1x4_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [WIDTH-1:0]       out0,
    output logic [WIDTH-1:0]       out1,
    output logic [WIDTH-1:0]       out2,
    output logic [WIDTH-1:0]       out3,
    output logic [LANES*CNT_W-1:0] lane_cnt
);

    logic [LANES-1:0] push_s;
    logic [LANES-1:0] full_s;
    logic [LANES-1:0] valid_s;
    logic [WIDTH-1:0] dout_s [LANES];
    logic [CNT_W-1:0] cnt_s  [LANES];

    // Readiness depends only on the selected lane's registered full flag, never on out_ready.
    always_comb begin
        case (in_sel)
            LANE_0:  in_ready = ~full_s[0];
            LANE_1:  in_ready = ~full_s[1];
            LANE_2:  in_ready = ~full_s[2];
            LANE_3:  in_ready = ~full_s[3];
            default: in_ready = 1'b0;
        endcase
    end

    // Decode the select into a one-hot push strobe for the accepted word.
    always_comb begin
        push_s = '0;
        if (in_valid && in_ready) begin
            push_s[in_sel] = 1'b1;
        end else begin
            push_s = '0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_fifo2 #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[g]),
            .pop   (out_ready[g]),
            .din   (in_data),
            .dout  (dout_s[g]),
            .valid (valid_s[g]),
            .full  (full_s[g]),
            .cnt   (cnt_s[g])
        );
    end

    assign out_valid = valid_s;
    assign out0      = dout_s[0];
    assign out1      = dout_s[1];
    assign out2      = dout_s[2];
    assign out3      = dout_s[3];
    assign lane_cnt  = {cnt_s[3], cnt_s[2], cnt_s[1], cnt_s[0]};

endmodule

// File: tb/tb_demux1x4_buf.sv
// Scoreboard bench for demux1x4_buf: per-lane queues of expected words are
// filled on acceptance and drained/compared by a monitor at the falling clock edge.
module tb_demux1x4_buf;
    import demux1x4_buf_pkg::*;

    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [W-1:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out0, out1, out2, out3;
    logic [7:0]   lane_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q [4][$];
    logic [W-1:0] disp  [4];
    logic [W-1:0] outs  [4];
    bit           exp_rdy;

    demux1x4_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .lane_cnt  (lane_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model: compare, then apply this cycle's pops and pushes.
    always @(negedge clk) begin
        outs = '{out0, out1, out2, out3};
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                exp_q[i].delete();
                disp[i] = '0;
                check($sformatf("rst_out%0d", i), 32'(outs[i]), 32'h0);
            end
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_lane_cnt", 32'(lane_cnt), 32'h0);
            check("rst_in_ready", 32'(in_ready), 32'h1);
        end else begin
            exp_rdy = (exp_q[in_sel].size() != D);
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cnt%0d", i), 32'(lane_cnt_of(lane_cnt, 2'(i))),
                      32'(exp_q[i].size()));
                check($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
                check($sformatf("out%0d", i), 32'(outs[i]),
                      32'((exp_q[i].size() != 0) ? exp_q[i][0] : disp[i]));
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_q[i].size() != 0 && out_ready[i]) begin
                    void'(exp_q[i].pop_front());
                end
            end
            if (in_valid && exp_rdy) begin
                exp_q[in_sel].push_back(in_data);
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_q[i].size() != 0) begin
                    disp[i] = exp_q[i][0];
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 16'hABCD;
        out_ready = 4'hF;
        #10;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Routing: one word per lane with all consumers ready.
        drive(1'b1, 2'd0, 16'h0000, 4'hF);
        drive(1'b1, 2'd1, 16'h0001, 4'hF);
        drive(1'b1, 2'd2, 16'h0002, 4'hF);
        drive(1'b1, 2'd3, 16'h0003, 4'hF);
        drive(1'b0, 2'd0, 16'h0000, 4'hF);
        drive(1'b0, 2'd0, 16'h0000, 4'hF);

        // Fill lane 2, attempt an overflow, then use lane 1.
        drive(1'b1, 2'd2, 16'h000F, 4'h0);
        drive(1'b1, 2'd2, 16'h000E, 4'h0);
        drive(1'b1, 2'd2, 16'h0055, 4'h0);
        drive(1'b1, 2'd1, 16'h000D, 4'h0);
        drive(1'b0, 2'd2, 16'h0000, 4'h0);

        // Drain lane 2 in order, then lane 1.
        drive(1'b0, 2'd2, 16'h0000, 4'b0100);
        drive(1'b0, 2'd2, 16'h0000, 4'b0100);
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);
        drive(1'b0, 2'd0, 16'h0000, 4'b0010);

        // Simultaneous push and pop on lane 0.
        drive(1'b1, 2'd0, 16'h1111, 4'b0000);
        drive(1'b1, 2'd0, 16'h2222, 4'b0001);
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);
        drive(1'b0, 2'd0, 16'h0000, 4'b0001);
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);

        // Reset with lanes 0 and 3 occupied.
        drive(1'b1, 2'd0, 16'hAAAA, 4'b0000);
        drive(1'b1, 2'd3, 16'hBBBB, 4'b0000);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 2'd0, 16'h0000, 4'hF);
        drive(1'b0, 2'd3, 16'h0000, 4'hF);
        drive(1'b1, 2'd2, 16'hCCCC, 4'hF);
        drive(1'b0, 2'd0, 16'h0000, 4'hF);
        drive(1'b0, 2'd0, 16'h0000, 4'hF);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), W'($urandom),
                  4'($urandom));
        end

        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 2'd0, 16'h0000, 4'hF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1x4_buf.md
Name: demux1x4_buf

Overview:
- Registered 1-to-4 demultiplexer with per-lane buffering; it performs the distribution that mux4X1 reverses.
- Takes one valid/ready input stream and steers each word, by a 2-bit select, to one of four output lanes.
- Each lane holds words in its own 2-entry FIFO until the consumer takes them.
- Used wherever one producer feeds four stage-local consumers, for example distributing results to four destination latches. Stalls on one lane never corrupt another lane.

Parameters:
- WIDTH, 16, data width of the input word and of each lane's data output.
- DEPTH, 2, entries per lane FIFO; the only supported values are 1 and 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_sel  input  2  destination lane index, 0 to 3.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit i set means lane i holds a word.
- out_ready  input  4  bit i set means lane i's consumer takes its head word this cycle.
- out0, out1, out2, out3  output  WIDTH each  head word of lanes 0 to 3.
- lane_cnt  output  8  occupancy of each lane, 2 bits per lane; lane i is bits [2i+1:2i].

Behaviour:
- Reset (rst low, asynchronous):
  - all lane counts go to 0; out_valid = 4'b0000; out0 to out3 = 0; lane_cnt = 0.
  - in_ready = 1 after reset, because every lane is empty.
  - Reset asserted mid-transfer discards all buffered words. No word is emitted after reset releases until a new word is accepted.
- Accept rule: an input word is accepted when in_valid && in_ready at a rising clk edge.
- in_ready = (cnt[in_sel] != DEPTH).
  - in_ready is combinational from in_sel and registered state only.
  - in_ready never depends on out_ready. A full lane cannot accept a word even if it is popped in the same cycle.
- Pop rule: lane i pops its head word on out_valid[i] && out_ready[i] at a rising clk edge.
  - All four lanes may pop in the same cycle.
- Latency: a word accepted at edge N is visible on out<sel> with out_valid[sel] = 1 after edge N, when the lane was empty. There is no combinational input-to-output path.
- Ordering: words within a lane come out in acceptance order. There is no ordering relation between lanes.
- Per-lane count update, for lane = in_sel:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together (only possible when cnt = 1): cnt unchanged; the new word becomes the head after the edge.
- Lanes other than in_sel are never written. A pop on an unselected lane proceeds independently in the same cycle.
- out_valid[i] = (cnt[i] != 0).
  - out_i holds its value while valid and not popped.
  - out_i holds its last value while invalid; it is not cleared except by reset.
- Storage: each lane has a 2-entry storage with a 1-bit write pointer and a 1-bit read pointer that wrap modulo 2. The count is kept separately and distinguishes full from empty.
- in_sel and in_data are ignored when in_valid = 0. An out_ready bit is ignored when its lane is empty.
- No arithmetic beyond the 2-bit counts.
  - The count never exceeds DEPTH.
  - The count never underflows below 0.

Decomposition:
- Shared package or include file:
  - constants LANES = 4, SEL_W = 2, default WIDTH = 16, DEPTH = 2.
  - a function that extracts a lane count from lane_cnt.
- Sub-module lane_fifo2:
  - one lane's storage, pointers and count.
  - ports: clk, rst, push, pop, din, dout, valid, full, cnt.
- Top level contains:
  - the select decode into four push strobes;
  - the in_ready mux driven by the lanes' full flags;
  - four lane_fifo2 instances.

Test Plan:
- Reset: hold rst low for 10 ns while in_valid = 1 -> out_valid = 0000, lane_cnt = 0, in_ready = 1, out0 to out3 = 0 throughout.
- Routing: with out_ready = 1111, send 16'h0000, 0001, 0002, 0003 with in_sel = 0, 1, 2, 3 on consecutive cycles -> each word appears on out0 to out3 respectively, one cycle after acceptance, with a single-cycle out_valid pulse per lane.
- Full lane and isolation:
  - with out_ready = 0000, push 16'h000F and then 16'h000E to lane 2 -> lane_cnt[5:4] = 2 and in_ready = 0 while in_sel = 2.
  - switching to in_sel = 1 -> in_ready = 1, and 16'h000D is accepted into lane 1.
- Order and drain: from the full lane 2 state, raise out_ready[2] for two cycles -> out2 shows 16'h000F and then 16'h000E, and lane 2's count steps 2, 1, 0.
- Simultaneous push and pop: lane 0 holds 16'h1111; set out_ready[0] = 1 and push 16'h2222 to lane 0 in the same cycle -> the count stays 1, out0 = 16'h2222 next cycle, and 16'h1111 was consumed exactly once.
- Reset mid-operation: with lanes 0 and 3 holding words, assert rst for one cycle -> all counts are 0 and out_valid = 0000 immediately. After release, no stale word reappears, and the next accepted word is the only output.
